// File: rtl/top.sv
// Self-running register-program sequencer: initialises A..D, loops A/B up by two
// until B reaches 10, then derives C and D from the loop results and halts.
module top (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] c,
    output logic [7:0] d
);

    localparam int unsigned W          = 8;
    localparam logic [W-1:0] LOOP_LIMIT = W'(10);
    localparam logic [W-1:0] LOOP_STEP  = W'(2);

    typedef enum logic [2:0] {
        ST_START,
        ST_LOOP,
        ST_FIN1,
        ST_FIN2,
        ST_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   c_q, c_d;
    logic [W-1:0]   d_q, d_d;

    // State and program registers; reset wins over every state action
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    // Next-state and register updates; every register holds unless its step writes it
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        case (state_q)
            ST_START: begin
                a_d     = W'(1);
                b_d     = '0;
                c_d     = '0;
                d_d     = '0;
                state_d = ST_LOOP;
            end
            ST_LOOP: begin
                if (b_q < LOOP_LIMIT) begin
                    a_d = W'(a_q + LOOP_STEP);
                    b_d = W'(b_q + LOOP_STEP);
                end else begin
                    state_d = ST_FIN1;
                end
            end
            ST_FIN1: begin
                c_d     = b_q;
                a_d     = W'(a_q + W'(1));
                state_d = ST_FIN2;
            end
            ST_FIN2: begin
                d_d     = W'(a_q - b_q);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    assign a = a_q;
    assign b = b_q;
    assign c = c_q;
    assign d = d_q;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the register-program sequencer: a driver issues reset
// patterns and queues the expected registers; a monitor checks each cycle.
module tb_top;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } regs_t;

    logic       clk;
    logic       rst;
    logic [7:0] a, b, c, d;

    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned edges_since_rst;
    regs_t       exp_q[$];

    top dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program semantics: A=1,B=0; while (B<10) {A+=2;B+=2}; C=B; A+=1; D=A-B.
    // n counts completed edges since reset; each program step costs one edge,
    // including the exiting loop test.
    function automatic regs_t model(input int unsigned n);
        regs_t r;
        int unsigned iters;
        int unsigned av, bv, cv, dv;
        r = '0;
        if (n == 0) return r;
        av = 1; bv = 0; cv = 0; dv = 0;
        iters = (n - 1 > 5) ? 5 : n - 1;
        av = av + 2 * iters;
        bv = bv + 2 * iters;
        if (n >= 8) begin
            cv = bv;
            av = av + 1;
        end
        if (n >= 9) dv = (av - bv) % 256;
        r.a = 8'(av % 256);
        r.b = 8'(bv % 256);
        r.c = 8'(cv % 256);
        r.d = 8'(dv % 256);
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    endtask

    // Drive rst for the coming edge and queue what the registers must read after it
    task automatic step(input logic r);
        rst = r;
        if (r) edges_since_rst = 0;
        else if (edges_since_rst < 1000) edges_since_rst++;
        exp_q.push_back(model(edges_since_rst));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int unsigned cycles, input logic r);
        for (int i = 0; i < int'(cycles); i++) step(r);
    endtask

    // Monitor: registers are sampled on the falling edge, well clear of the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL queue_underflow: no expected entry at %0t", $time);
            end else begin
                regs_t e;
                e = exp_q.pop_front();
                check("a", a, e.a);
                check("b", b, e.b);
                check("c", c, e.c);
                check("d", d, e.d);
            end
        end
    end

    initial begin
        regs_t fin;
        n_checks        = 0;
        n_pass          = 0;
        edges_since_rst = 0;
        rst             = 1'b1;

        run(1, 1'b1);
        run(14, 1'b0);
        run(100, 1'b0);

        run(1, 1'b1);
        run(4, 1'b0);
        run(1, 1'b1);
        run(9, 1'b0);
        run(3, 1'b0);

        run(5, 1'b1);
        run(12, 1'b0);

        run(1, 1'b1);
        run(12, 1'b0);

        for (int i = 0; i < 200; i++) step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);

        run(1, 1'b1);
        run(20, 1'b0);
        @(negedge clk);
        #1;

        fin = model(9);
        check("final_a", a, fin.a);
        check("final_b", b, fin.b);
        check("final_c", c, fin.c);
        check("final_d", d, fin.d);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d, required 0 pending entries", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 a  output  8  program register A, driven directly from a flop.
REQ-005 b  output  8  program register B (loop counter), driven directly from a flop.
REQ-006 c  output  8  program register C, driven directly from a flop.
REQ-007 d  output  8  program register D, driven directly from a flop.

Function
REQ-008 The block SHALL be a self-running sequencer with no inputs other than clk/rst, stepping through states START, LOOP, FIN1, FIN2, DONE.
REQ-009 Each state SHALL occupy exactly one clock edge per visit; no combinational path from rst to outputs.
REQ-010 START: on the next edge, a<=1, b<=0, c<=0, d<=0; next state LOOP.
REQ-011 LOOP with b<10 (unsigned compare): on the edge, b<=b+2, a<=a+2, c and d hold; state stays LOOP.
REQ-012 LOOP with b>=10: on the edge, no register changes; next state FIN1.
REQ-013 FIN1: on the edge, c<=b and a<=a+1 (both use pre-edge values); b and d hold; next state FIN2.
REQ-014 FIN2: on the edge, d<=a-b using the registered values; a, b, c hold; next state DONE.
REQ-015 DONE: all registers hold indefinitely; state stays DONE until rst.
REQ-016 All arithmetic SHALL be 8-bit unsigned, wrap-around modulo 256.
REQ-017 Required trace (edges counted after rst deasserts): edge1 a=1 b=0; edge2 a=3 b=2; edge3 a=5 b=4; edge4 a=7 b=6; edge5 a=9 b=8; edge6 a=11 b=10; edge7 no change; edge8 a=12 c=10; edge9 d=2.
REQ-018 Final values from edge 9 onward SHALL be a=12, b=10, c=10, d=2.
REQ-019 c SHALL read 0 through edge 7 and d SHALL read 0 through edge 8.
REQ-020 Outputs SHALL be glitch-free register outputs with no X after the first reset edge.

Reset
REQ-021 While rst=1 on a rising edge: state<=START, a=b=c=d=0.
REQ-022 rst has priority over every state action, including mid-LOOP, FIN1, FIN2 and DONE.
REQ-023 After rst deasserts, the sequence SHALL restart from START exactly as in REQ-017.
REQ-024 rst held for multiple cycles SHALL keep all outputs at 0 and state at START.
REQ-025 Register values before the first reset edge are don't-care.

Verification
REQ-026 rst=1 for 1 cycle, then 14 cycles -> a=12, b=10, c=10, d=2.
REQ-027 Sample after every edge 1..9 -> exact trace of REQ-017, with c and d still 0 before edges 8 and 9 respectively.
REQ-028 After completion, run 100 more cycles -> a=12, b=10, c=10, d=2 unchanged.
REQ-029 Assert rst on edge 5 (mid-LOOP) -> outputs 0 after that edge; deassert -> final values again after 9 further edges.
REQ-030 Hold rst for 5 cycles -> all outputs 0 throughout; release -> edge1 a=1, b=0.
REQ-031 Assert rst during DONE -> all outputs 0 on the next edge, then the full sequence repeats.
